controle_datapath: RTL

Control sequencer that drives the stack/temp/ULA datapath from the other side of its control interface. It accepts one instruction at a time over a valid/ready handshake and expands it into the multi-cycle sequence of push/pop, temp-load, operand-select and opcode signals the datapath expects. All datapath updates use single-clock enable strobes instead of separate stack/temp clocks. It tracks stack occupancy to reject underflow/overflow and registers the ULA comparison flag for IF-class instructions.

---
 rtl/controle_datapath.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/controle_datapath.sv
// Control sequencer for the stack/temp/ULA datapath: expands one accepted
// instruction into its multi-cycle strobe sequence and tracks stack occupancy.
module controle_datapath #(
    parameter  int PROF_PILHA = 8,
    localparam int NW         = $clog2(PROF_PILHA + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [1:0]    instr_classe,
    input  logic [4:0]    instr_op,
    input  logic [15:0]   instr_imm,
    input  logic          flag_ula,
    output logic          push,
    output logic          pop,
    output logic          controle_pilha,
    output logic          en_pilha,
    output logic          load_temp1,
    output logic          load_temp2,
    output logic          en_temp1,
    output logic          en_temp2,
    output logic [4:0]    opcode,
    output logic [15:0]   din_UC,
    output logic          done,
    output logic          erro,
    output logic          branch_taken,
    output logic [NW-1:0] nivel
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH,
        S_POPT,
        S_LD1,
        S_LD2,
        S_EXEC,
        S_WB,
        S_FLAG,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        C_PUSHI = 2'b00,
        C_POPT  = 2'b01,
        C_ULA   = 2'b10,
        C_IF    = 2'b11
    } classe_t;

    localparam logic [NW-1:0] NIV_MAX = NW'(PROF_PILHA);
    localparam logic [NW-1:0] NIV_UM  = NW'(1);
    localparam logic [NW-1:0] NIV_DOIS = NW'(2);

    state_t         state_q, state_d;
    classe_t        classe_q, classe_d;
    logic [NW-1:0]  nivel_q, nivel_d;
    logic [4:0]     opcode_q, opcode_d;
    logic [15:0]    din_q, din_d;
    logic           sel_q, sel_d;
    logic           branch_q, branch_d;

    classe_t        classe_in;
    logic           legal;
    state_t         alvo;

    assign classe_in = classe_t'(instr_classe);

    // Legality is judged against the occupancy seen at the accept edge.
    always_comb begin
        legal = 1'b0;
        alvo  = S_IDLE;
        unique case (classe_in)
            C_PUSHI: begin
                legal = (nivel_q < NIV_MAX);
                alvo  = S_PUSH;
            end
            C_POPT: begin
                legal = (nivel_q >= NIV_UM);
                alvo  = S_POPT;
            end
            C_ULA, C_IF: begin
                legal = (nivel_q >= NIV_DOIS);
                alvo  = S_LD1;
            end
            default: begin
                legal = 1'b0;
                alvo  = S_IDLE;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        classe_d = classe_q;
        nivel_d  = nivel_q;
        opcode_d = opcode_q;
        din_d    = din_q;
        sel_d    = sel_q;
        branch_d = branch_q;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    opcode_d = instr_op;
                    din_d    = instr_imm;
                    sel_d    = instr_imm[0];
                    classe_d = classe_in;
                    state_d  = legal ? alvo : S_ERR;
                end
            end
            S_PUSH: begin
                nivel_d = nivel_q + NIV_UM;
                state_d = S_IDLE;
            end
            S_POPT: begin
                nivel_d = nivel_q - NIV_UM;
                state_d = S_IDLE;
            end
            S_LD1: begin
                nivel_d = nivel_q - NIV_UM;
                state_d = S_LD2;
            end
            S_LD2: begin
                nivel_d = nivel_q - NIV_UM;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (classe_q == C_IF) begin
                    branch_d = flag_ula;
                    state_d  = S_FLAG;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                nivel_d = nivel_q + NIV_UM;
                state_d = S_IDLE;
            end
            S_FLAG, S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            classe_q <= C_PUSHI;
            nivel_q  <= '0;
            opcode_q <= '0;
            din_q    <= '0;
            sel_q    <= 1'b0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            classe_q <= classe_d;
            nivel_q  <= nivel_d;
            opcode_q <= opcode_d;
            din_q    <= din_d;
            sel_q    <= sel_d;
            branch_q <= branch_d;
        end
    end

    // Moore strobe decode from the registered state only.
    always_comb begin
        push           = 1'b0;
        pop            = 1'b0;
        controle_pilha = 1'b0;
        en_pilha       = 1'b0;
        load_temp1     = 1'b0;
        load_temp2     = 1'b0;
        en_temp1       = 1'b0;
        en_temp2       = 1'b0;
        done           = 1'b0;
        erro           = 1'b0;
        unique case (state_q)
            S_PUSH: begin
                push     = 1'b1;
                en_pilha = 1'b1;
                done     = 1'b1;
            end
            S_POPT: begin
                pop        = 1'b1;
                en_pilha   = 1'b1;
                load_temp1 = ~sel_q;
                en_temp1   = ~sel_q;
                load_temp2 = sel_q;
                en_temp2   = sel_q;
                done       = 1'b1;
            end
            S_LD1: begin
                pop        = 1'b1;
                en_pilha   = 1'b1;
                load_temp1 = 1'b1;
                en_temp1   = 1'b1;
            end
            S_LD2: begin
                pop        = 1'b1;
                en_pilha   = 1'b1;
                load_temp2 = 1'b1;
                en_temp2   = 1'b1;
            end
            S_WB: begin
                push           = 1'b1;
                controle_pilha = 1'b1;
                en_pilha       = 1'b1;
                done           = 1'b1;
            end
            S_FLAG: begin
                done = 1'b1;
            end
            S_ERR: begin
                done = 1'b1;
                erro = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign instr_ready  = (state_q == S_IDLE);
    assign opcode       = opcode_q;
    assign din_UC       = din_q;
    assign branch_taken = branch_q;
    assign nivel        = nivel_q;

endmodule
